alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Execute-stage controller for the 8-bit ALU and flag_register. Accepts ALU commands over a
//  valid/ready handshake and owns the accumulator register. Repeats one op 1..2^CNT_W times
//  (e.g. rotate-by-N, add-N) and drives alu acc/src/alu_op/carry plus flag_register update_flags.
//  Sits between the instruction decoder and the ALU; ALU and flag_register instantiated by parent.
// PARAMETERS
//  DATA_WIDTH   8  operand/accumulator width
//  ALU_OP_BITS  4  alu_op width
//  CNT_W        3  repeat-count width; iterations = cmd_count+1 (1..8)
// PORTS
//  clk            in   1            system clock, rising edge
//  reset          in   1            synchronous, active-low reset
//  cmd_valid      in   1            command offered
//  cmd_ready      out  1            block can accept (IDLE only)
//  cmd_op         in   ALU_OP_BITS  ALU opcode (PASS..NOT = 0..10)
//  cmd_src        in   DATA_WIDTH   source operand, latched at accept
//  cmd_count      in   CNT_W        repeat count minus one
//  cmd_use_carry  in   1            1: alu carry_in = carry_flag; 0: carry_in = 0
//  acc_load       in   1            load accumulator directly (honoured in IDLE only)
//  acc_load_data  in   DATA_WIDTH   value for acc_load
//  alu_acc        out  DATA_WIDTH   to ALU acc (= acc_q)
//  alu_src        out  DATA_WIDTH   to ALU src (latched cmd_src)
//  alu_op         out  ALU_OP_BITS  to ALU alu_op
//  alu_carry_in   out  1            to ALU carry_flag input
//  alu_result     in   DATA_WIDTH+1 ALU temp_result
//  carry_flag     in   1            current flag_register carry
//  update_flags   out  1            to flag_register
//  acc_q          out  DATA_WIDTH   architectural accumulator
//  busy           out  1            high in EXEC and DONE
//  done           out  1            1-cycle pulse at command completion
//  illegal        out  1            1-cycle pulse with done when cmd_op > 4'b1010
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, acc_q=0, latched op=PASS, src=0, count=0;
//    outputs: cmd_ready=1 after reset released, busy=0, done=0, illegal=0, update_flags=0, alu_op=PASS.
//  - FSM IDLE -> EXEC -> DONE -> IDLE.
//    IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready at edge T: latch op/src/count/use_carry; go EXEC.
//    EXEC: one iteration per cycle. update_flags=1 (legal op); acc_q <= alu_result[7:0] at edge.
//      Remaining counter decrements; after the last iteration go DONE. N=cmd_count+1 EXEC cycles.
//    DONE: done=1 (and illegal if op illegal) for one cycle; update_flags=0; next IDLE.
//  - Latency: accept edge T; EXEC cycles T+1..T+N; done high in cycle T+N+1; cmd_ready again T+N+2.
//  - Flags and acc_q update on the same edge each iteration, so iteration k+1 sees carry_flag of k.
//  - alu_carry_in = cmd_use_carry_q & carry_flag, combinational, only meaningful in EXEC.
//  - Outside EXEC: alu_op=PASS, update_flags=0; alu_acc/alu_src still reflect acc_q/src_q.
//  - Illegal op (>10): no acc_q write, update_flags=0 throughout, still runs N EXEC cycles.
//  - acc_load in IDLE: acc_q <= acc_load_data. Same cycle as accept: load applies, command
//    then operates on loaded value. acc_load while busy ignored (no effect, no error).
//  - cmd_valid while busy: held off by cmd_ready=0; command must remain stable until accepted.
//  - Counter does not wrap: count=2^CNT_W-1 gives exactly 8 iterations.
//  - Reset mid-command: abort immediately, state/outputs to reset values, no done pulse.
// STRUCTURE
//  - alu_pkg: DATA_WIDTH/ALU_OP_BITS constants, OP_PASS..OP_NOT localparams, OP_LAST=OP_NOT,
//    seq_state_t enum {IDLE, EXEC, DONE}. Shared with alu and decoder.
//  - Single module; no sub-module. ALU and flag_register are siblings wired by the parent.
// TESTING (bench instantiates alu_sequencer + alu + flag_register)
//  1 acc_load 0x01, ADD src 0x02 cnt0 carry0 -> acc_q=0x03, Z=0 S=0 C=0, done at T+2, 1 update_flags.
//  2 acc_load 0xFE, INC cnt7 -> 8 EXEC cycles, acc_q=0x06, done at T+9, cmd_ready=0 T+1..T+9.
//  3 acc 0xFF, carry_flag=1, ADD src 0x01 use_carry=1 -> acc_q=0x01, C=1, Z=0.
//  4 INC cnt7 from 0x00, reset low during 3rd EXEC -> acc_q=0, busy=0, no done, cmd_ready=1 after.
//  5 cmd_op 4'b1111 cnt1 -> acc_q unchanged, update_flags never 1, done+illegal at T+3.
//  6 two back-to-back ADD 0x01 cmds, cmd_valid held -> 2nd accepted at T+3, acc_q +2 total.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encodings and the sequencer state type.
// Used by the ALU, the instruction decoder and the execute-stage sequencer.
package alu_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int ALU_OP_BITS = 4;

   localparam logic [ALU_OP_BITS-1:0] OP_PASS = 4'd0;
   localparam logic [ALU_OP_BITS-1:0] OP_ADD  = 4'd1;
   localparam logic [ALU_OP_BITS-1:0] OP_SUB  = 4'd2;
   localparam logic [ALU_OP_BITS-1:0] OP_INC  = 4'd3;
   localparam logic [ALU_OP_BITS-1:0] OP_DEC  = 4'd4;
   localparam logic [ALU_OP_BITS-1:0] OP_AND  = 4'd5;
   localparam logic [ALU_OP_BITS-1:0] OP_OR   = 4'd6;
   localparam logic [ALU_OP_BITS-1:0] OP_XOR  = 4'd7;
   localparam logic [ALU_OP_BITS-1:0] OP_ROL  = 4'd8;
   localparam logic [ALU_OP_BITS-1:0] OP_ROR  = 4'd9;
   localparam logic [ALU_OP_BITS-1:0] OP_NOT  = 4'd10;
   localparam logic [ALU_OP_BITS-1:0] OP_LAST = OP_NOT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   function automatic logic op_is_legal(input logic [ALU_OP_BITS-1:0] op);
      return (op <= OP_LAST);
   endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Execute-stage controller: accepts ALU commands, owns the accumulator and repeats one
// op 1..2^CNT_W times, driving the sibling ALU and flag_register each iteration.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = alu_pkg::DATA_WIDTH,
   parameter int ALU_OP_BITS = alu_pkg::ALU_OP_BITS,
   parameter int CNT_W       = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ALU_OP_BITS-1:0] cmd_op,
   input  logic [DATA_WIDTH-1:0]  cmd_src,
   input  logic [CNT_W-1:0]       cmd_count,
   input  logic                   cmd_use_carry,
   input  logic                   acc_load,
   input  logic [DATA_WIDTH-1:0]  acc_load_data,
   output logic [DATA_WIDTH-1:0]  alu_acc,
   output logic [DATA_WIDTH-1:0]  alu_src,
   output logic [ALU_OP_BITS-1:0] alu_op,
   output logic                   alu_carry_in,
   input  logic [DATA_WIDTH:0]    alu_result,
   input  logic                   carry_flag,
   output logic                   update_flags,
   output logic [DATA_WIDTH-1:0]  acc_q,
   output logic                   busy,
   output logic                   done,
   output logic                   illegal
);

   seq_state_t             r_state;
   seq_state_t             w_state_nxt;
   logic [DATA_WIDTH-1:0]  r_acc;
   logic [DATA_WIDTH-1:0]  r_src;
   logic [ALU_OP_BITS-1:0] r_op;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_use_carry;
   logic                   w_accept;
   logic                   w_legal;
   logic                   w_last;
   logic                   w_unused_cout;

   assign w_accept = cmd_valid && (r_state == IDLE);
   assign w_legal  = op_is_legal(r_op);
   assign w_last   = (r_cnt == '0);

   // The ALU carry-out is captured by flag_register; the accumulator keeps only the data bits.
   assign w_unused_cout = alu_result[DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      cmd_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      illegal      = 1'b0;
      update_flags = 1'b0;
      alu_op       = OP_PASS;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_state_nxt = EXEC;
         end
         EXEC: begin
            busy         = 1'b1;
            alu_op       = r_op;
            update_flags = w_legal;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            illegal     = !w_legal;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A load in the accept cycle lands first, so the command's first iteration sees the loaded value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_acc       <= '0;
         r_src       <= '0;
         r_op        <= OP_PASS;
         r_cnt       <= '0;
         r_use_carry <= 1'b0;
      end else begin
         if (r_state == IDLE && acc_load)
            r_acc <= acc_load_data;
         else if (r_state == EXEC && w_legal)
            r_acc <= alu_result[DATA_WIDTH-1:0];

         if (w_accept) begin
            r_op        <= cmd_op;
            r_src       <= cmd_src;
            r_cnt       <= cmd_count;
            r_use_carry <= cmd_use_carry;
         end else if (r_state == EXEC && !w_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

   assign alu_acc      = r_acc;
   assign alu_src      = r_src;
   assign acc_q        = r_acc;
   assign alu_carry_in = r_use_carry & carry_flag;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU and flag register
// standing in for the sibling blocks.
module tb_alu_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_src;
   logic [2:0] cmd_count;
   logic       cmd_use_carry;
   logic       acc_load;
   logic [7:0] acc_load_data;
   logic [7:0] alu_acc;
   logic [7:0] alu_src;
   logic [3:0] alu_op;
   logic       alu_carry_in;
   logic [8:0] alu_result;
   logic       carry_flag;
   logic       update_flags;
   logic [7:0] acc_q;
   logic       busy;
   logic       done;
   logic       illegal;

   logic f_c, f_z, f_s;
   int   n_total = 0;
   int   n_bad   = 0;
   int   upd_n   = 0;
   int   done_n  = 0;
   logic rdy_seen;

   alu_sequencer #(.DATA_WIDTH(8), .ALU_OP_BITS(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_src(cmd_src),
      .cmd_count(cmd_count), .cmd_use_carry(cmd_use_carry),
      .acc_load(acc_load), .acc_load_data(acc_load_data),
      .alu_acc(alu_acc), .alu_src(alu_src), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
      .alu_result(alu_result), .carry_flag(carry_flag), .update_flags(update_flags),
      .acc_q(acc_q), .busy(busy), .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: 9-bit result, bit 8 is carry-out.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         OP_PASS: alu_result = {1'b0, alu_src};
         OP_ADD:  alu_result = {1'b0, alu_acc} + {1'b0, alu_src} + {8'b0, alu_carry_in};
         OP_SUB:  alu_result = {1'b0, alu_acc} - {1'b0, alu_src} - {8'b0, alu_carry_in};
         OP_INC:  alu_result = {1'b0, alu_acc} + 9'd1;
         OP_DEC:  alu_result = {1'b0, alu_acc} - 9'd1;
         OP_AND:  alu_result = {1'b0, alu_acc & alu_src};
         OP_OR:   alu_result = {1'b0, alu_acc | alu_src};
         OP_XOR:  alu_result = {1'b0, alu_acc ^ alu_src};
         OP_ROL:  alu_result = {alu_acc[7], alu_acc[6:0], alu_acc[7]};
         OP_ROR:  alu_result = {alu_acc[0], alu_acc[0], alu_acc[7:1]};
         OP_NOT:  alu_result = {1'b0, ~alu_acc};
         default: alu_result = '0;
      endcase
   end

   always @(posedge clk) begin
      if (!reset) begin
         f_c <= 1'b0; f_z <= 1'b0; f_s <= 1'b0;
      end else if (update_flags) begin
         f_c <= alu_result[8];
         f_z <= (alu_result[7:0] == 8'h00);
         f_s <= alu_result[7];
      end
   end
   assign carry_flag = f_c;

   always @(negedge clk) begin
      if (update_flags) upd_n++;
      if (done)         done_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns #1 after the accept edge.
   task automatic send(input logic [3:0] op, input logic [7:0] src, input logic [2:0] cnt,
                       input logic uc, input logic ld, input logic [7:0] ldd, input logic hold);
      cmd_op = op; cmd_src = src; cmd_count = cnt; cmd_use_carry = uc;
      acc_load = ld; acc_load_data = ldd; cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) chk("send_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      acc_load = 1'b0;
      if (!hold) cmd_valid = 1'b0;
   endtask

   // Counts negedges after the accept edge; k = index of the negedge where done is high, -1 on timeout.
   task automatic wait_done(input int k0, output int k);
      k = -1;
      for (int i = k0 + 1; i <= 40; i++) begin
         @(negedge clk);
         if (cmd_ready) rdy_seen = 1'b1;
         if (done) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int u0;
      int d0;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_count = '0;
      cmd_use_carry = 1'b0; acc_load = 1'b0; acc_load_data = '0; rdy_seen = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_upd", update_flags, 0);
      chk("rst_aluop", alu_op, OP_PASS);
      chk("rst_acc", acc_q, 0);

      // 1: load 0x01, ADD 0x02 once
      u0 = upd_n;
      send(OP_ADD, 8'h02, 3'd0, 1'b0, 1'b1, 8'h01, 1'b0);
      wait_done(0, k);
      chk("t1_done_lat", k, 2);
      chk("t1_acc", acc_q, 8'h03);
      chk("t1_flags_zsc", {f_z, f_s, f_c}, 3'b000);
      chk("t1_upd_cnt", upd_n - u0, 1);
      chk("t1_illegal", illegal, 0);
      @(negedge clk);
      chk("t1_ready_after", cmd_ready, 1);
      chk("t1_done_clr", done, 0);

      // 2: load 0xFE, INC x8
      u0 = upd_n; rdy_seen = 1'b0;
      send(OP_INC, 8'h00, 3'd7, 1'b0, 1'b1, 8'hFE, 1'b0);
      wait_done(0, k);
      chk("t2_done_lat", k, 9);
      chk("t2_ready_low", rdy_seen, 0);
      chk("t2_acc", acc_q, 8'h06);
      chk("t2_upd_cnt", upd_n - u0, 8);
      @(negedge clk);
      chk("t2_ready_after", cmd_ready, 1);

      // 3: set C via 0xFF+0x01, then add with carry, then add ignoring carry
      send(OP_ADD, 8'h01, 3'd0, 1'b0, 1'b1, 8'hFF, 1'b0);
      wait_done(0, k);
      chk("t3a_acc", acc_q, 8'h00);
      chk("t3a_flags_zc", {f_z, f_c}, 2'b11);
      @(negedge clk);
      send(OP_ADD, 8'h01, 3'd0, 1'b1, 1'b1, 8'hFF, 1'b0);
      @(negedge clk);
      chk("t3_cin", alu_carry_in, 1);
      chk("t3_aluop", alu_op, OP_ADD);
      wait_done(1, k);
      chk("t3_acc", acc_q, 8'h01);
      chk("t3_flags_zc", {f_z, f_c}, 2'b01);
      @(negedge clk);
      send(OP_ADD, 8'h01, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("t3b_cin_masked", alu_carry_in, 0);
      wait_done(1, k);
      chk("t3b_acc", acc_q, 8'h02);
      @(negedge clk);

      // 4: reset in the third EXEC cycle of INC x8
      d0 = done_n;
      send(OP_INC, 8'h00, 3'd7, 1'b0, 1'b1, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      chk("t4_acc_mid", acc_q, 8'h02);
      chk("t4_busy_mid", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("t4_acc_rst", acc_q, 8'h00);
      chk("t4_busy_rst", busy, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("t4_ready", cmd_ready, 1);
      chk("t4_aluop", alu_op, OP_PASS);
      repeat (3) @(negedge clk);
      chk("t4_no_done", done_n - d0, 0);

      // 5: illegal 0xF x2 with acc_load attempted while busy
      u0 = upd_n;
      send(4'hF, 8'h55, 3'd1, 1'b0, 1'b1, 8'h3C, 1'b0);
      acc_load = 1'b1; acc_load_data = 8'h99;
      wait_done(0, k);
      chk("t5_done_lat", k, 3);
      chk("t5_illegal", illegal, 1);
      chk("t5_acc", acc_q, 8'h3C);
      acc_load = 1'b0;
      @(negedge clk);
      chk("t5_upd_none", upd_n - u0, 0);
      chk("t5_illegal_clr", illegal, 0);
      chk("t5_acc_after", acc_q, 8'h3C);

      // 5b: op 10 is the last legal opcode, op 11 the first illegal one
      send(OP_NOT, 8'h00, 3'd0, 1'b0, 1'b1, 8'h0F, 1'b0);
      wait_done(0, k);
      chk("t5b_not_illegal", illegal, 0);
      chk("t5b_not_acc", acc_q, 8'hF0);
      @(negedge clk);
      send(4'd11, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
      wait_done(0, k);
      chk("t5c_op11_lat", k, 2);
      chk("t5c_op11_illegal", illegal, 1);
      chk("t5c_op11_acc", acc_q, 8'hF0);
      @(negedge clk);

      // 6: two back-to-back ADD 0x01 with cmd_valid held
      d0 = done_n;
      send(OP_ADD, 8'h01, 3'd0, 1'b0, 1'b1, 8'h10, 1'b1);
      wait_done(0, k);
      chk("t6_first_lat", k, 2);
      chk("t6_acc_first", acc_q, 8'h11);
      @(negedge clk);
      chk("t6_ready_t3", cmd_ready, 1);
      @(negedge clk);
      chk("t6_busy_second", busy, 1);
      chk("t6_upd_second", update_flags, 1);
      cmd_valid = 1'b0;
      wait_done(4, k);
      chk("t6_second_lat", k, 5);
      chk("t6_acc", acc_q, 8'h12);
      @(negedge clk);
      chk("t6_done_cnt", done_n - d0, 2);
      chk("t6_idle", cmd_ready, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
